// File: rtl/procyon_rr_arbiter.sv
// procyon_rr_arbiter: registered round-robin arbiter.
// Samples a request vector and picks one requester using rotating priority.
// The winner is presented as a one-hot grant with a valid/ready handshake.
// The pointer names the highest-priority requester for the next load.
module procyon_rr_arbiter #(
  parameter int OPTN_NUM_REQ = 8,
  parameter int PTR_WIDTH    = (OPTN_NUM_REQ > 1) ? $clog2(OPTN_NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPTN_NUM_REQ-1:0] i_req,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [OPTN_NUM_REQ-1:0] o_grant
);

  localparam int unsigned NREQ = OPTN_NUM_REQ;

  logic                    valid_q, valid_d;
  logic [OPTN_NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_WIDTH-1:0]    ptr_q,   ptr_d;

  logic                    load;
  logic                    hit;
  logic [PTR_WIDTH-1:0]    win_idx;
  int unsigned             idx;

  // A new grant may be loaded when nothing is held or the held one is taken.
  assign load = !valid_q || i_ready;

  // Rotating scan starting at ptr_q, wrapping past the last requester to 0.
  // ptr_q is always below NREQ, so a single subtraction is enough to wrap.
  always_comb begin
    hit     = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      idx = 32'(ptr_q) + j;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!hit && i_req[idx]) begin
        hit     = 1'b1;
        win_idx = PTR_WIDTH'(idx);
      end
    end
  end

  // Next state: hold while stalled, otherwise load the winner or go idle.
  always_comb begin
    valid_d = valid_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (hit) begin
        valid_d = 1'b1;
        grant_d = OPTN_NUM_REQ'(1) << win_idx;
        ptr_d   = (32'(win_idx) == NREQ - 1) ? '0 : win_idx + PTR_WIDTH'(1);
      end else begin
        valid_d = 1'b0;
        grant_d = '0;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_valid = valid_q;
  assign o_grant = grant_q;

endmodule

// File: tb/tb_procyon_rr_arbiter.sv
// Bench for procyon_rr_arbiter: directed steps plus random traffic on an
// 8-requester and a 5-requester instance, checked against a modulo-arithmetic
// reference model of the rotating-priority rules.
module tb_procyon_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req8;
  logic       rdy8;
  logic       valid8;
  logic [7:0] grant8;
  logic [4:0] req5;
  logic       rdy5;
  logic       valid5;
  logic [4:0] grant5;

  int checks = 0;
  int errors = 0;

  // model state, index 0 = 8-requester DUT, index 1 = 5-requester DUT
  logic       m_valid [2];
  logic [7:0] m_grant [2];
  int         m_ptr   [2];

  always #5 clk = ~clk;

  procyon_rr_arbiter #(.OPTN_NUM_REQ(8)) dut8 (
    .clk(clk), .rst(rst), .i_req(req8), .i_ready(rdy8),
    .o_valid(valid8), .o_grant(grant8)
  );

  procyon_rr_arbiter #(.OPTN_NUM_REQ(5)) dut5 (
    .clk(clk), .rst(rst), .i_req(req5), .i_ready(rdy5),
    .o_valid(valid5), .o_grant(grant5)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Reference: first requesting index at distance 0..n-1 from ptr (mod n).
  function automatic void model_step(input int d, input int n, input logic r,
                                     input logic [7:0] req, input logic rdy);
    int g;
    g = -1;
    if (r) begin
      m_valid[d] = 1'b0;
      m_grant[d] = '0;
      m_ptr[d]   = 0;
    end else if (!m_valid[d] || rdy) begin
      for (int k = 0; k < n; k++)
        if (g < 0 && req[(m_ptr[d] + k) % n]) g = (m_ptr[d] + k) % n;
      if (g >= 0) begin
        m_valid[d] = 1'b1;
        m_grant[d] = 8'(1) << g;
        m_ptr[d]   = (g + 1) % n;
      end else begin
        m_valid[d] = 1'b0;
        m_grant[d] = '0;
      end
    end
  endfunction

  // One clock: drive inputs, advance the models, compare both DUTs.
  task automatic cyc(input string tag, input logic r, input logic [7:0] q8,
                     input logic rd8, input logic [4:0] q5, input logic rd5);
    rst  = r;
    req8 = q8;
    rdy8 = rd8;
    req5 = q5;
    rdy5 = rd5;
    @(posedge clk);
    #1;
    model_step(0, 8, r, q8, rd8);
    model_step(1, 5, r, {3'b000, q5}, rd5);
    chk({tag, ".v8"}, {7'd0, valid8}, {7'd0, m_valid[0]});
    chk({tag, ".g8"}, grant8, m_grant[0]);
    chk({tag, ".v5"}, {7'd0, valid5}, {7'd0, m_valid[1]});
    chk({tag, ".g5"}, {3'b000, grant5}, m_grant[1]);
  endtask

  initial begin
    logic       r;
    logic [7:0] q8;
    logic [4:0] q5;
    logic       rd8, rd5;

    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0;
      m_grant[d] = '0;
      m_ptr[d]   = 0;
    end
    rst = 1'b1; req8 = '0; rdy8 = 1'b1; req5 = '0; rdy5 = 1'b1;

    // reset held with all requests asserted
    cyc("rst0", 1'b1, 8'hFF, 1'b1, 5'h1F, 1'b1);
    chk("rst_grant", grant8, 8'h00);
    cyc("rst1", 1'b1, 8'hFF, 1'b1, 5'h1F, 1'b1);
    chk("rst_valid", {7'd0, valid8}, 8'h00);
    cyc("first", 1'b0, 8'hFF, 1'b1, 5'h1F, 1'b1);
    chk("first_grant", grant8, 8'h01);

    // full rotation with every requester pending
    for (int i = 1; i <= 8; i++) begin
      cyc("rot", 1'b0, 8'hFF, 1'b1, 5'h1F, 1'b1);
      chk("rot_grant", grant8, 8'(1) << (i % 8));
      chk("rot_valid", {7'd0, valid8}, 8'h01);
    end

    // stall holds grant while requests change
    cyc("st_rst", 1'b1, 8'h00, 1'b1, 5'h00, 1'b1);
    cyc("st_load", 1'b0, 8'h24, 1'b0, 5'h00, 1'b1);
    chk("st_load", grant8, 8'h04);
    for (int i = 0; i < 3; i++) begin
      cyc("st_hold", 1'b0, 8'h80, 1'b0, 5'h00, 1'b1);
      chk("st_hold", grant8, 8'h04);
    end
    cyc("st_rel", 1'b0, 8'h80, 1'b1, 5'h00, 1'b1);
    chk("st_rel", grant8, 8'h80);

    // wrap from pointer 7 to requester 0
    cyc("wr_rst", 1'b1, 8'h00, 1'b1, 5'h00, 1'b1);
    cyc("wr_b6", 1'b0, 8'h40, 1'b1, 5'h00, 1'b1);
    chk("wr_b6", grant8, 8'h40);
    cyc("wr_wrap", 1'b0, 8'h41, 1'b1, 5'h00, 1'b1);
    chk("wr_wrap", grant8, 8'h01);
    cyc("wr_back", 1'b0, 8'h41, 1'b1, 5'h00, 1'b1);
    chk("wr_back", grant8, 8'h40);

    // non-power-of-two instance alternates between its end requesters
    cyc("n5_rst", 1'b1, 8'h00, 1'b1, 5'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc("n5", 1'b0, 8'h00, 1'b1, 5'b10001, 1'b1);
      chk("n5_grant", {3'b000, grant5}, (i % 2 == 0) ? 8'h01 : 8'h10);
    end

    // idle gap keeps the pointer; reset during a stall drops the grant
    cyc("gap_rst", 1'b1, 8'h00, 1'b1, 5'h00, 1'b1);
    for (int i = 0; i < 3; i++) cyc("gap_pre", 1'b0, 8'hFF, 1'b1, 5'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc("gap_idle", 1'b0, 8'h00, 1'b1, 5'h00, 1'b1);
      chk("gap_idle", grant8, 8'h00);
    end
    cyc("gap_resume", 1'b0, 8'hFF, 1'b1, 5'h00, 1'b1);
    chk("gap_resume", grant8, 8'h08);
    cyc("gap_stall", 1'b0, 8'hFF, 1'b0, 5'h00, 1'b1);
    chk("gap_stall", grant8, 8'h08);
    cyc("gap_rstpulse", 1'b1, 8'hFF, 1'b0, 5'h00, 1'b1);
    chk("gap_rstpulse", {7'd0, valid8}, 8'h00);
    cyc("gap_after", 1'b0, 8'hFF, 1'b1, 5'h00, 1'b1);
    chk("gap_after", grant8, 8'h01);

    // random traffic on both instances
    for (int i = 0; i < 500; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      q8  = 8'($urandom);
      q5  = 5'($urandom);
      if ($urandom_range(0, 5) == 0) q8 = '0;
      if ($urandom_range(0, 5) == 0) q5 = '0;
      rd8 = ($urandom_range(0, 3) != 0);
      rd5 = ($urandom_range(0, 3) != 0);
      cyc("rand", r, q8, rd8, q5, rd5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
